sprite_rom_arbiter: RTL and testbench
=====================================

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter NUM_SLOTS, default 8: number of sprite slots sharing one glyph ROM.
REQ-002 Parameter WIDTH, default 72: glyph width in pixels.
REQ-003 Parameter HEIGHT, default 56: glyph height in pixels.
REQ-004 Parameter ROM_AW, default 16: ROM address width.
REQ-005 Parameter ROM_LATENCY, default 2: ROM read latency in clocks, fixed.
REQ-006 pixel_clk  in  1: single clock; all logic is posedge pixel_clk.
REQ-007 reset  in  1: synchronous, active-high reset.
REQ-008 hcount  in  11: current pixel column.
REQ-009 vcount  in  10: current pixel row.
REQ-010 cfg_we  in  1: single-cycle slot configuration write strobe.
REQ-011 cfg_slot  in  3: slot index written.
REQ-012 cfg_x  in  11: slot left edge.
REQ-013 cfg_y  in  10: slot top edge.
REQ-014 cfg_glyph  in  3: glyph index within ROM.
REQ-015 cfg_en  in  1: slot enable.
REQ-016 rom_addr  out  ROM_AW: registered address to the shared glyph ROM.
REQ-017 rom_data  in  8: ROM output, valid ROM_LATENCY clocks after rom_addr.
REQ-018 pixel  out  24: {3{rom_data}} on hit, else 0.
REQ-019 hit  out  1: pixel is covered by an enabled slot; aligned with pixel.
REQ-020 slot_id  out  3: winning slot, aligned with pixel; 0 when hit=0.

Function
REQ-021 Slot i covers (hcount,vcount) when enabled, x<=hcount<x+WIDTH and y<=vcount<y+HEIGHT; sums computed one bit wider, so no wrap at the right or bottom edges.
REQ-022 When several slots cover a pixel, the lowest slot index wins (fixed priority).
REQ-023 Stage 1 register: rom_addr = glyph*WIDTH*HEIGHT + (hcount-x) + (vcount-y)*WIDTH of the winner, plus hit and slot_id; on a miss, rom_addr = 0.
REQ-024 hit and slot_id are delayed ROM_LATENCY further stages, so pixel, hit and slot_id appear exactly 1+ROM_LATENCY = 3 clocks after the hcount/vcount sample.
REQ-025 pixel = {3{rom_data}} when the delayed hit=1, else 24'h0, and is registered in the final stage.
REQ-026 Config writes go to shadow registers only; active slot registers are unchanged until commit.
REQ-027 Commit happens on the cycle with hcount==0 and vcount==0: all shadow slots are copied to active in one clock and take effect for the following pixel sample.
REQ-028 A cfg_we in the commit cycle updates the shadow only; it is applied at the next frame's commit.
REQ-029 Repeated writes to one slot before commit: the last write wins.
REQ-030 No stalls: one pixel is accepted every clock; the ROM port is read every clock.

Reset
REQ-031 Reset clears every shadow and active slot: en=0, x=0, y=0, glyph=0.
REQ-032 Reset clears all pipeline stages: rom_addr=0, hit=0, slot_id=0, pixel=0.
REQ-033 Reset mid-frame drops in-flight pixels; outputs stay 0 until 3 clocks after reset deasserts and until a commit enables a slot.

Structure
REQ-034 The shared package holds NUM_SLOTS, WIDTH, HEIGHT, ROM_AW, ROM_LATENCY, glyph base stride WIDTH*HEIGHT, and the slot record type (x, y, glyph, en).
REQ-035 The per-slot coverage compare and local offset are a natural sub-module, sprite_slot_hit, instantiated NUM_SLOTS times.
REQ-036 The ROM is external and not instantiated here.

Verification
REQ-037 Slot0 x=100 y=50 glyph=2 committed; sample (100,50) -> 3 clocks later hit=1, slot_id=0, rom_addr was 8064; sample (172,50) -> hit=0, pixel=0.
REQ-038 Slot1 and slot3 both cover (200,200) -> slot_id=1; disable slot1 and commit -> slot_id=3.
REQ-039 Write slot2 mid-frame at (300,300) -> no hit at (300,300) this frame; hit=1 after the next (0,0) commit; a write in the commit cycle is deferred one frame.
REQ-040 Slot x=2040: sample hcount=2047 -> hit=1; hcount=0 on the same row -> hit=0 (no wrap).
REQ-041 Assert reset with 3 pixels in flight -> hit=0 and pixel=0 on the following clock; all slots are disabled after release.
REQ-042 ROM model returning addr[7:0] -> pixel equals {3{expected addr[7:0]}} for a continuous scan across one glyph.

Source files
------------

// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared constants and slot record for the sprite ROM arbiter.
package sprite_rom_arbiter_pkg;

    localparam int NUM_SLOTS    = 8;
    localparam int WIDTH        = 72;
    localparam int HEIGHT       = 56;
    localparam int ROM_AW       = 16;
    localparam int ROM_LATENCY  = 2;
    localparam int GLYPH_STRIDE = WIDTH * HEIGHT;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;
    localparam int SLOT_W   = 3;
    localparam int GLYPH_W  = 3;

    // One sprite slot: left edge, top edge, glyph index, enable.
    typedef struct packed {
        logic [HCOUNT_W-1:0] x;
        logic [VCOUNT_W-1:0] y;
        logic [GLYPH_W-1:0]  glyph;
        logic                en;
    } slot_t;

    localparam slot_t SLOT_CLEAR = '0;

endpackage

// File: rtl/sprite_rom_arbiter_slot_hit.sv
// Coverage test and glyph-local offset for one sprite slot.
module sprite_slot_hit #(
    parameter int WIDTH  = sprite_rom_arbiter_pkg::WIDTH,
    parameter int HEIGHT = sprite_rom_arbiter_pkg::HEIGHT
) (
    input  sprite_rom_arbiter_pkg::slot_t slot_i,
    input  logic [10:0]                   hcount_i,
    input  logic [9:0]                    vcount_i,
    output logic                          hit_o,
    output logic [10:0]                   dx_o,
    output logic [9:0]                    dy_o
);
    import sprite_rom_arbiter_pkg::*;

    // Extend by one bit so a slot near the right/bottom edge never wraps to column/row 0.
    logic [HCOUNT_W:0] h_ext, x_lo, x_hi;
    logic [VCOUNT_W:0] v_ext, y_lo, y_hi;

    assign h_ext = {1'b0, hcount_i};
    assign x_lo  = {1'b0, slot_i.x};
    assign x_hi  = x_lo + (HCOUNT_W+1)'(WIDTH);
    assign v_ext = {1'b0, vcount_i};
    assign y_lo  = {1'b0, slot_i.y};
    assign y_hi  = y_lo + (VCOUNT_W+1)'(HEIGHT);

    assign hit_o = slot_i.en && (h_ext >= x_lo) && (h_ext < x_hi)
                             && (v_ext >= y_lo) && (v_ext < y_hi);
    assign dx_o  = hcount_i - slot_i.x;
    assign dy_o  = vcount_i - slot_i.y;

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Fixed-priority arbiter of sprite slots onto one shared glyph ROM port.
// Config is double-buffered and committed at pixel (0,0); pixel/hit/slot_id
// emerge 1+ROM_LATENCY clocks after the hcount/vcount sample.
module sprite_rom_arbiter #(
    parameter int NUM_SLOTS   = sprite_rom_arbiter_pkg::NUM_SLOTS,
    parameter int WIDTH       = sprite_rom_arbiter_pkg::WIDTH,
    parameter int HEIGHT      = sprite_rom_arbiter_pkg::HEIGHT,
    parameter int ROM_AW      = sprite_rom_arbiter_pkg::ROM_AW,
    parameter int ROM_LATENCY = sprite_rom_arbiter_pkg::ROM_LATENCY
) (
    input  logic              pixel_clk_i,
    input  logic              reset_i,
    input  logic [10:0]       hcount_i,
    input  logic [9:0]        vcount_i,
    input  logic              cfg_we_i,
    input  logic [2:0]        cfg_slot_i,
    input  logic [10:0]       cfg_x_i,
    input  logic [9:0]        cfg_y_i,
    input  logic [2:0]        cfg_glyph_i,
    input  logic              cfg_en_i,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [7:0]        rom_data_i,
    output logic [23:0]       pixel_o,
    output logic              hit_o,
    output logic [2:0]        slot_id_o
);
    import sprite_rom_arbiter_pkg::*;

    localparam int STRIDE = WIDTH * HEIGHT;

    slot_t shadow_q [NUM_SLOTS];
    slot_t active_q [NUM_SLOTS];

    logic        slot_hit [NUM_SLOTS];
    logic [10:0] slot_dx  [NUM_SLOTS];
    logic [9:0]  slot_dy  [NUM_SLOTS];

    logic              win_hit_d;
    logic [2:0]        win_idx_d;
    logic [ROM_AW-1:0] rom_addr_d;

    logic [ROM_AW-1:0] rom_addr_q;
    logic              hit_sr_q  [ROM_LATENCY];
    logic [2:0]        slot_sr_q [ROM_LATENCY];
    logic              hit_q;
    logic [2:0]        slot_id_q;
    logic [23:0]       pixel_q;

    logic commit;
    assign commit = (hcount_i == '0) && (vcount_i == '0);

    // Shadow takes writes; active is reloaded from the pre-write shadow at commit,
    // so a write landing in the commit cycle waits for the next frame.
    always_ff @(posedge pixel_clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                shadow_q[i] <= SLOT_CLEAR;
                active_q[i] <= SLOT_CLEAR;
            end
        end else begin
            if (commit) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            if (cfg_we_i) begin
                shadow_q[cfg_slot_i] <= '{x: cfg_x_i, y: cfg_y_i, glyph: cfg_glyph_i, en: cfg_en_i};
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        sprite_slot_hit #(
            .WIDTH  (WIDTH),
            .HEIGHT (HEIGHT)
        ) u_hit (
            .slot_i   (active_q[g]),
            .hcount_i (hcount_i),
            .vcount_i (vcount_i),
            .hit_o    (slot_hit[g]),
            .dx_o     (slot_dx[g]),
            .dy_o     (slot_dy[g])
        );
    end

    // Lowest covering slot wins; scan downward so the last assignment is the lowest index.
    always_comb begin
        win_hit_d  = 1'b0;
        win_idx_d  = '0;
        rom_addr_d = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_hit[i]) begin
                win_hit_d = 1'b1;
                win_idx_d = 3'(i);
            end
        end
        if (win_hit_d) begin
            rom_addr_d = ROM_AW'(active_q[win_idx_d].glyph) * ROM_AW'(STRIDE)
                       + ROM_AW'(slot_dx[win_idx_d])
                       + ROM_AW'(slot_dy[win_idx_d]) * ROM_AW'(WIDTH);
        end
    end

    // Stage 1 drives the ROM; hit/slot ride alongside for ROM_LATENCY clocks,
    // then the final stage gates the returned byte into the pixel.
    always_ff @(posedge pixel_clk_i) begin
        if (reset_i) begin
            rom_addr_q <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                hit_sr_q[i]  <= 1'b0;
                slot_sr_q[i] <= '0;
            end
            hit_q     <= 1'b0;
            slot_id_q <= '0;
            pixel_q   <= '0;
        end else begin
            rom_addr_q   <= rom_addr_d;
            hit_sr_q[0]  <= win_hit_d;
            slot_sr_q[0] <= win_idx_d;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                hit_sr_q[i]  <= hit_sr_q[i-1];
                slot_sr_q[i] <= slot_sr_q[i-1];
            end
            hit_q     <= hit_sr_q[ROM_LATENCY-1];
            slot_id_q <= slot_sr_q[ROM_LATENCY-1];
            pixel_q   <= hit_sr_q[ROM_LATENCY-1] ? {3{rom_data_i}} : 24'h0;
        end
    end

    assign rom_addr_o = rom_addr_q;
    assign hit_o      = hit_q;
    assign slot_id_o  = slot_id_q;
    assign pixel_o    = pixel_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed + randomized bench for sprite_rom_arbiter with a frame-level reference model.
module tb_sprite_rom_arbiter;

    localparam int W  = 72;
    localparam int H  = 56;
    localparam int NS = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_slot = '0;
    logic [10:0] cfg_x = '0;
    logic [9:0]  cfg_y = '0;
    logic [2:0]  cfg_glyph = '0;
    logic        cfg_en = 1'b0;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data = '0;
    logic [23:0] pixel;
    logic        hit;
    logic [2:0]  slot_id;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // External ROM: one internal register, returns the low address byte.
    always @(posedge clk) rom_data <= rom_addr[7:0];

    sprite_rom_arbiter dut (
        .pixel_clk_i (clk),
        .reset_i     (reset),
        .hcount_i    (hcount),
        .vcount_i    (vcount),
        .cfg_we_i    (cfg_we),
        .cfg_slot_i  (cfg_slot),
        .cfg_x_i     (cfg_x),
        .cfg_y_i     (cfg_y),
        .cfg_glyph_i (cfg_glyph),
        .cfg_en_i    (cfg_en),
        .rom_addr_o  (rom_addr),
        .rom_data_i  (rom_data),
        .pixel_o     (pixel),
        .hit_o       (hit),
        .slot_id_o   (slot_id)
    );

    typedef struct {
        bit hit;
        int slot;
        int addr;
    } exp_t;

    exp_t q[$];
    int  sh_x[NS], sh_y[NS], sh_g[NS];
    bit  sh_en[NS];
    int  ac_x[NS], ac_y[NS], ac_g[NS];
    bit  ac_en[NS];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model_pixel(input int h, input int v);
        exp_t e;
        e.hit = 0; e.slot = 0; e.addr = 0;
        for (int i = 0; i < NS; i++) begin
            if (!e.hit && ac_en[i] && h >= ac_x[i] && h < ac_x[i] + W
                       && v >= ac_y[i] && v < ac_y[i] + H) begin
                e.hit  = 1;
                e.slot = i;
                e.addr = ac_g[i] * W * H + (h - ac_x[i]) + (v - ac_y[i]) * W;
            end
        end
        return e;
    endfunction

    // Present one pixel (with any pending cfg write), advance one clock, check outputs.
    task automatic step(input int h, input int v);
        exp_t e, r;
        logic [7:0] b;
        hcount = 11'(h);
        vcount = 10'(v);
        e = model_pixel(h, v);
        if (h == 0 && v == 0) begin
            for (int i = 0; i < NS; i++) begin
                ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i]; ac_g[i] = sh_g[i]; ac_en[i] = sh_en[i];
            end
        end
        if (cfg_we) begin
            sh_x[cfg_slot] = int'(cfg_x); sh_y[cfg_slot] = int'(cfg_y);
            sh_g[cfg_slot] = int'(cfg_glyph); sh_en[cfg_slot] = cfg_en;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        chk("rom_addr", 32'(rom_addr), 32'(q[$].addr));
        r = q[q.size() - 3];
        b = r.addr[7:0];
        chk("hit", 32'(hit), 32'(r.hit));
        chk("slot_id", 32'(slot_id), 32'(r.slot));
        chk("pixel", 32'(pixel), r.hit ? 32'({b, b, b}) : 32'h0);
        if (q.size() > 4) void'(q.pop_front());
    endtask

    task automatic set_cfg(input int s, input int x, input int y, input int g, input bit en);
        cfg_we = 1'b1; cfg_slot = 3'(s); cfg_x = 11'(x); cfg_y = 10'(y);
        cfg_glyph = 3'(g); cfg_en = en;
    endtask

    task automatic do_reset();
        exp_t z;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_hit", 32'(hit), 32'h0);
        chk("rst_pixel", 32'(pixel), 32'h0);
        chk("rst_slot_id", 32'(slot_id), 32'h0);
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < NS; i++) begin
            sh_x[i] = 0; sh_y[i] = 0; sh_g[i] = 0; sh_en[i] = 0;
            ac_x[i] = 0; ac_y[i] = 0; ac_g[i] = 0; ac_en[i] = 0;
        end
        q.delete();
        z.hit = 0; z.slot = 0; z.addr = 0;
        q.push_back(z);
        q.push_back(z);
    endtask

    initial begin
        int h, v, r;
        do_reset();

        // Single slot, right-edge exclusion
        set_cfg(0, 100, 50, 2, 1); step(5, 5);
        step(0, 0);
        step(100, 50); chk("s0_addr_8064", 32'(rom_addr), 32'd8064);
        step(172, 50);
        step(10, 10); chk("s0_hit", 32'(hit), 32'h1); chk("s0_slot", 32'(slot_id), 32'h0);
        step(11, 10); chk("s0_right_miss", 32'(hit), 32'h0); chk("s0_right_pix", 32'(pixel), 32'h0);

        // Priority between overlapping slots
        set_cfg(1, 180, 180, 1, 1); step(1, 1);
        set_cfg(3, 190, 190, 3, 1); step(2, 1);
        step(0, 0);
        step(200, 200); step(10, 10); step(10, 10);
        chk("prio_slot1", 32'(slot_id), 32'h1);
        set_cfg(1, 180, 180, 1, 0); step(3, 1);
        step(0, 0);
        step(200, 200); step(10, 10); step(10, 10);
        chk("prio_slot3", 32'(slot_id), 32'h3); chk("prio_hit3", 32'(hit), 32'h1);

        // Shadow write not visible until commit; commit-cycle write deferred a frame
        set_cfg(2, 300, 300, 4, 1); step(50, 60);
        step(300, 300); step(10, 10); step(10, 10);
        chk("shadow_no_hit", 32'(hit), 32'h0);
        step(0, 0);
        step(300, 300); step(10, 10); step(10, 10);
        chk("commit_hit", 32'(hit), 32'h1); chk("commit_slot2", 32'(slot_id), 32'h2);
        set_cfg(2, 300, 300, 4, 0); step(0, 0);
        step(300, 300); step(10, 10); step(10, 10);
        chk("defer_still_hit", 32'(hit), 32'h1);
        step(0, 0);
        step(300, 300); step(10, 10); step(10, 10);
        chk("defer_applied", 32'(hit), 32'h0);

        // Right-edge no-wrap
        set_cfg(4, 2040, 400, 0, 1); step(7, 7);
        step(0, 0);
        step(2047, 400); step(10, 10); step(10, 10);
        chk("edge_hit", 32'(hit), 32'h1); chk("edge_slot4", 32'(slot_id), 32'h4);
        step(0, 400); step(10, 10); step(10, 10);
        chk("edge_nowrap", 32'(hit), 32'h0);

        // Continuous scan across slot 0's glyph (pixel = ROM byte)
        for (int y = 48; y < 108; y++)
            for (int x = 98; x < 176; x++) step(x, y);

        // Randomized writes, commits and samples
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 10)
                set_cfg($urandom_range(0, 7),
                        ($urandom_range(0, 9) == 0) ? $urandom_range(1980, 2047) : $urandom_range(0, 400),
                        $urandom_range(0, 350), $urandom_range(0, 7), $urandom_range(0, 3) != 0);
            if (r >= 5 && r < 9) begin
                step(0, 0);
            end else begin
                h = ($urandom_range(0, 9) == 0) ? $urandom_range(1980, 2047) : $urandom_range(0, 480);
                v = $urandom_range(0, 420);
                step(h, v);
            end
        end

        // Reset with pixels in flight
        set_cfg(0, 100, 50, 2, 1); step(1, 1);
        step(0, 0);
        step(100, 50); step(101, 50); step(102, 50);
        do_reset();
        step(0, 0);
        step(100, 50); step(101, 50); step(102, 50);
        chk("post_rst_nohit", 32'(hit), 32'h0);
        for (int x = 95; x < 180; x++) step(x, 52);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
